// File: rtl/morse_symbol_sequencer_if.sv
// Handshake/data bundle between the Morse sequencer, the 16:1 symbol mux and the output driver.
// master = sequencer side, slave = surrounding logic (mux, message select, LED/buzzer driver).
interface morse_symbol_sequencer_if;
  logic       start;
  logic [2:0] symbol;
  logic [3:0] sel;
  logic       morse_out;
  logic       busy;
  logic       done;

  modport master (
    input  start,
    input  symbol,
    output sel,
    output morse_out,
    output busy,
    output done
  );

  modport slave (
    output start,
    output symbol,
    input  sel,
    input  morse_out,
    input  busy,
    input  done
  );
endinterface

// File: rtl/morse_symbol_sequencer.sv
// Walks up to 16 symbol slots through the external mux and keys DOT/DASH/gap timing on morse_out.
// Optional MORSE_REPEAT_EN: replays the message after a 7-unit word gap while start stays high.
module morse_symbol_sequencer #(
  parameter int unsigned UNIT_CYCLES = 5000000,
  parameter int unsigned SLOTS       = 16
) (
  input logic                      clk,
  input logic                      rst,
  morse_symbol_sequencer_if.master bus
);

  localparam int unsigned CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CycMax  = CW'(UNIT_CYCLES - 1);
  localparam logic [3:0]    LastSel = 4'(SLOTS - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StFetch  = 3'd1;
  localparam logic [2:0] StKey    = 3'd2;
  localparam logic [2:0] StSpace  = 3'd3;
  localparam logic [2:0] StFinish = 3'd4;
`ifdef MORSE_REPEAT_EN
  localparam logic [2:0] StGap    = 3'd5;
`endif

  localparam logic [2:0] SymDot       = 3'b001;
  localparam logic [2:0] SymDash      = 3'b010;
  localparam logic [2:0] SymLetterGap = 3'b011;
  localparam logic [2:0] SymWordGap   = 3'b100;

  logic [2:0]    r_state, w_state_d;
  logic [3:0]    r_sel, w_sel_d;
  logic          r_out, w_out_d;
  logic          r_busy, w_busy_d;
  logic          r_done, w_done_d;
  logic [CW-1:0] r_cyc, w_cyc_d;
  logic [2:0]    r_units, w_units_d;
  logic          w_tick;
  logic          w_last;

  assign w_tick = (r_cyc == CycMax);
  // r_units counts remaining units; the element ends on the wrap of its final unit
  assign w_last = w_tick && (r_units == 3'd1);

  always_comb begin
    w_state_d = r_state;
    w_sel_d   = r_sel;
    w_out_d   = r_out;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    w_cyc_d   = r_cyc;
    w_units_d = r_units;

    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_d = StFetch;
          w_sel_d   = 4'd0;
          w_busy_d  = 1'b1;
        end
      end

      StFetch: begin
        w_cyc_d = '0;
        unique case (bus.symbol)
          SymDot: begin
            w_state_d = StKey;
            w_units_d = 3'd1;
            w_out_d   = 1'b1;
          end
          SymDash: begin
            w_state_d = StKey;
            w_units_d = 3'd3;
            w_out_d   = 1'b1;
          end
          SymLetterGap: begin
            w_state_d = StSpace;
            w_units_d = 3'd2;
          end
          SymWordGap: begin
            w_state_d = StSpace;
            w_units_d = 3'd6;
          end
          default: begin
            w_state_d = StFinish;
            w_done_d  = 1'b1;
          end
        endcase
      end

      StKey: begin
        w_cyc_d = w_tick ? '0 : r_cyc + CW'(1);
        if (w_last) begin
          w_state_d = StSpace;
          w_units_d = 3'd1;
          w_out_d   = 1'b0;
        end else if (w_tick) begin
          w_units_d = r_units - 3'd1;
        end
      end

      StSpace: begin
        w_cyc_d = w_tick ? '0 : r_cyc + CW'(1);
        if (w_last) begin
          if (r_sel == LastSel) begin
            w_state_d = StFinish;
            w_done_d  = 1'b1;
          end else begin
            w_state_d = StFetch;
            w_sel_d   = r_sel + 4'd1;
          end
        end else if (w_tick) begin
          w_units_d = r_units - 3'd1;
        end
      end

      StFinish: begin
`ifdef MORSE_REPEAT_EN
        if (bus.start) begin
          w_state_d = StGap;
          w_units_d = 3'd7;
          w_sel_d   = 4'd0;
          w_cyc_d   = '0;
        end else begin
          w_state_d = StIdle;
          w_busy_d  = 1'b0;
          w_sel_d   = 4'd0;
        end
`else
        w_state_d = StIdle;
        w_busy_d  = 1'b0;
        w_sel_d   = 4'd0;
`endif
      end

`ifdef MORSE_REPEAT_EN
      StGap: begin
        w_cyc_d = w_tick ? '0 : r_cyc + CW'(1);
        if (w_last) begin
          w_state_d = StFetch;
        end else if (w_tick) begin
          w_units_d = r_units - 3'd1;
        end
      end
`endif

      default: begin
        w_state_d = StIdle;
        w_sel_d   = 4'd0;
        w_out_d   = 1'b0;
        w_busy_d  = 1'b0;
        w_cyc_d   = '0;
        w_units_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_sel   <= 4'd0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cyc   <= '0;
      r_units <= 3'd0;
    end else begin
      r_state <= w_state_d;
      r_sel   <= w_sel_d;
      r_out   <= w_out_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_cyc   <= w_cyc_d;
      r_units <= w_units_d;
    end
  end

  assign bus.sel       = r_sel;
  assign bus.morse_out = r_out;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule
